// File: rtl/tiny45_mem_arbiter.sv
// tiny45_mem_arbiter
// Shares the single nibble-serial memory port between the instruction fetcher
// and the load/store path. One transaction at a time: a combinational grant in
// IDLE latches address, direction and length, then START pulses mem_start,
// XFER moves nibbles to/from the owner, and STOP pulses mem_stop after an
// aborted fetch. Data has priority, bounded by DATA_BURST_MAX consecutive data
// grants while a fetch is waiting.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_req/addr/abort          fetch request, address, branch-taken abort
//   instr_gnt/data/valid/done     fetch grant pulse and nibble return
//   data_req/write/size/addr      load/store request
//   data_wdata                    store nibble, advanced on data_valid
//   data_gnt/rdata/valid/done     load/store grant pulse and nibble handshake
//   mem_start/stop                transaction begin / early-terminate pulses
//   mem_addr/write/nibbles        latched transaction attributes
//   mem_wdata, mem_rdata          nibble data to/from memory
//   mem_ready                     memory moves one nibble this cycle
module tiny45_mem_arbiter #(
    parameter int unsigned DATA_BURST_MAX = 2,
    parameter int unsigned ADDR_BITS      = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_req,
    input  logic [ADDR_BITS-1:0] instr_addr,
    input  logic                 instr_abort,
    output logic                 instr_gnt,
    output logic [3:0]           instr_data,
    output logic                 instr_valid,
    output logic                 instr_done,
    input  logic                 data_req,
    input  logic                 data_write,
    input  logic [1:0]           data_size,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [3:0]           data_wdata,
    output logic                 data_gnt,
    output logic [3:0]           data_rdata,
    output logic                 data_valid,
    output logic                 data_done,
    output logic                 mem_start,
    output logic                 mem_stop,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_write,
    output logic [3:0]           mem_nibbles,
    output logic [3:0]           mem_wdata,
    input  logic [3:0]           mem_rdata,
    input  logic                 mem_ready
);

    localparam logic [2:0] BurstMax = 3'(DATA_BURST_MAX);

    typedef enum logic [1:0] {StIdle, StStart, StXfer, StStop} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             count_q, count_d;
    logic [2:0]             burst_q, burst_d;
    logic                   owner_data_q, owner_data_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   write_q, write_d;
    logic [3:0]             nib_q, nib_d;
    logic                   quiet_q;
    logic                   quiet;
    logic                   last;
    logic                   fetch_abort;
    logic [3:0]             data_nib;

    // Outputs stay silent during reset and the cycle right after it.
    assign quiet       = rst | quiet_q;
    assign last        = ({1'b0, count_q} == (nib_q - 4'd1));
    assign fetch_abort = !owner_data_q && instr_abort;

    assign mem_addr    = addr_q;
    assign mem_write   = write_q;
    assign mem_nibbles = nib_q;
    assign mem_wdata   = data_wdata;

    always_comb begin
        case (data_size)
            2'b00:   data_nib = 4'd2;
            2'b01:   data_nib = 4'd4;
            default: data_nib = 4'd8;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        burst_d      = burst_q;
        owner_data_d = owner_data_q;
        addr_d       = addr_q;
        write_d      = write_q;
        nib_d        = nib_q;
        instr_gnt    = 1'b0;
        instr_data   = 4'd0;
        instr_valid  = 1'b0;
        instr_done   = 1'b0;
        data_gnt     = 1'b0;
        data_rdata   = 4'd0;
        data_valid   = 1'b0;
        data_done    = 1'b0;
        mem_start    = 1'b0;
        mem_stop     = 1'b0;

        if (!quiet) begin
            case (state_q)
                StIdle: begin
                    if (data_req && (!instr_req || (burst_q < BurstMax))) begin
                        data_gnt     = 1'b1;
                        owner_data_d = 1'b1;
                        addr_d       = data_addr;
                        write_d      = data_write;
                        nib_d        = data_nib;
                        state_d      = StStart;
                    end else if (instr_req && !instr_abort) begin
                        instr_gnt    = 1'b1;
                        owner_data_d = 1'b0;
                        addr_d       = instr_addr;
                        write_d      = 1'b0;
                        nib_d        = 4'd8;
                        state_d      = StStart;
                    end
                    // Burst only counts data grants made while a fetch waits.
                    if (!instr_req) begin
                        burst_d = 3'd0;
                    end else if (data_gnt) begin
                        burst_d = burst_q + 3'd1;
                    end else if (instr_gnt) begin
                        burst_d = 3'd0;
                    end
                end
                StStart: begin
                    mem_start = 1'b1;
                    state_d   = fetch_abort ? StStop : StXfer;
                end
                StXfer: begin
                    if (fetch_abort) begin
                        // The nibble in the abort cycle is never reported.
                        count_d = 3'd0;
                        state_d = StStop;
                    end else if (mem_ready) begin
                        if (owner_data_q) begin
                            data_valid = 1'b1;
                            data_rdata = mem_rdata;
                            data_done  = last;
                        end else begin
                            instr_valid = 1'b1;
                            instr_data  = mem_rdata;
                            instr_done  = last;
                        end
                        if (last) begin
                            count_d = 3'd0;
                            state_d = StIdle;
                        end else begin
                            count_d = count_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    mem_stop = 1'b1;
                    count_d  = 3'd0;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            count_q      <= 3'd0;
            burst_q      <= 3'd0;
            owner_data_q <= 1'b0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            nib_q        <= 4'd0;
            quiet_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            burst_q      <= burst_d;
            owner_data_q <= owner_data_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            nib_q        <= nib_d;
            quiet_q      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tiny45_mem_arbiter.sv
// Self-checking bench for tiny45_mem_arbiter: IDLE-arbitration vector table,
// hand-written multi-cycle sequences, and randomized traffic compared every
// cycle against a transaction-phase reference model.
module tb_tiny45_mem_arbiter;

    localparam int AB   = 28;
    localparam int MAXB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_req = 1'b0, instr_abort = 1'b0, data_req = 1'b0, data_write = 1'b0;
    logic [AB-1:0] instr_addr = '0, data_addr = '0;
    logic [1:0]    data_size = 2'd0;
    logic [3:0]    data_wdata = 4'd0, mem_rdata = 4'd0;
    logic          mem_ready = 1'b0;
    logic          instr_gnt, instr_valid, instr_done, data_gnt, data_valid, data_done;
    logic          mem_start, mem_stop, mem_write;
    logic [3:0]    instr_data, data_rdata, mem_nibbles, mem_wdata;
    logic [AB-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tiny45_mem_arbiter #(.DATA_BURST_MAX(MAXB), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_abort(instr_abort),
        .instr_gnt(instr_gnt), .instr_data(instr_data), .instr_valid(instr_valid),
        .instr_done(instr_done),
        .data_req(data_req), .data_write(data_write), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rdata(data_rdata), .data_valid(data_valid), .data_done(data_done),
        .mem_start(mem_start), .mem_stop(mem_stop), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_nibbles(mem_nibbles), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction phases) ----------------
    // phase: 0 idle, 1 start, 2 transfer, 3 stop; left = nibbles still owed.
    int            m_phase = 0;
    bit            m_own_d = 1'b0;
    int            m_left  = 0;
    int            m_burst = 0;
    logic [AB-1:0] m_addr  = '0;
    bit            m_wr    = 1'b0;
    int            m_len   = 0;
    bit            m_quiet = 1'b0;
    bit            m_live  = 1'b0;

    always @(negedge clk) begin : model
        logic [63:0]   a, e;
        logic [AB-1:0] ea;
        logic [3:0]    eidat, eddat;
        bit            q, ew, eig, edg, eiv, eid, edv, edd, ems, emt;
        int            en;
        #2;
        if (rst) m_live = 1'b1;
        q = rst || m_quiet;
        ea = m_addr; ew = m_wr; en = m_len;
        eig = 0; edg = 0; eiv = 0; eid = 0; edv = 0; edd = 0; ems = 0; emt = 0;
        eidat = 4'd0; eddat = 4'd0;
        if (!q) begin
            case (m_phase)
                0: begin
                    if (data_req && (!instr_req || m_burst < MAXB)) begin
                        edg = 1; m_own_d = 1; m_addr = data_addr; m_wr = data_write;
                        m_len = (data_size == 2'd0) ? 2 : (data_size == 2'd1) ? 4 : 8;
                        m_left = m_len; m_phase = 1;
                    end else if (instr_req && !instr_abort) begin
                        eig = 1; m_own_d = 0; m_addr = instr_addr; m_wr = 0;
                        m_len = 8; m_left = 8; m_phase = 1;
                    end
                    if (!instr_req) m_burst = 0;
                    else if (edg) m_burst++;
                    else if (eig) m_burst = 0;
                end
                1: begin
                    ems = 1;
                    m_phase = (!m_own_d && instr_abort) ? 3 : 2;
                end
                2: begin
                    if (!m_own_d && instr_abort) begin
                        m_phase = 3;
                    end else if (mem_ready) begin
                        m_left--;
                        if (m_own_d) begin
                            edv = 1; eddat = mem_rdata; edd = (m_left == 0);
                        end else begin
                            eiv = 1; eidat = mem_rdata; eid = (m_left == 0);
                        end
                        if (m_left == 0) m_phase = 0;
                    end
                end
                default: begin
                    emt = 1; m_phase = 0;
                end
            endcase
        end
        if (rst) begin
            m_phase = 0; m_own_d = 0; m_left = 0; m_burst = 0;
            m_addr = '0; m_wr = 0; m_len = 0;
        end
        m_quiet = rst;
        if (m_live) begin
            a = {11'd0, instr_gnt, data_gnt, instr_valid, instr_done, instr_data, data_valid,
                 data_done, data_rdata, mem_start, mem_stop, mem_addr, mem_write, mem_nibbles,
                 mem_wdata};
            e = {11'd0, eig, edg, eiv, eid, eidat, edv, edd, eddat, ems, emt, ea, ew, 4'(en),
                 data_wdata};
            chk("model", a, e);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        instr_req = 0; instr_abort = 0; data_req = 0; data_write = 0; data_size = 2'd0;
        mem_ready = 0; mem_rdata = 4'd0; data_wdata = 4'd0;
    endtask

    // Returns at the start of the first (silent) cycle after reset.
    task automatic do_reset();
        @(negedge clk); idle_inputs(); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    // Grants a fetch in the next cycle and steps into START with mem_ready=1.
    task automatic start_fetch(input logic [AB-1:0] addr, input string tag);
        @(negedge clk); instr_req = 1; instr_addr = addr; #1;
        chk({tag, "_gnt"}, instr_gnt, 1);
        @(negedge clk); instr_req = 0; mem_ready = 1; mem_rdata = 4'hF; #1;
        chk({tag, "_start"}, mem_start, 1);
        chk({tag, "_start_novalid"}, instr_valid, 0);
    endtask

    typedef struct {
        bit       ireq;
        bit       iab;
        bit       dreq;
        bit       dwr;
        bit [1:0] dsz;
        bit       e_ig;
        bit       e_dg;
        bit [3:0] e_nib;
        bit       e_wr;
    } vec_t;

    vec_t vecs[9];
    int   order[6];
    int   exp_order[6] = '{1, 1, 0, 1, 1, 0};

    initial begin
        logic [AB-1:0] ea;
        bit [3:0]      pat;
        int            n;
        bit            ip, dp, pig, pdg;

        vecs[0] = '{1, 0, 0, 0, 2'd0, 1, 0, 4'd0, 0};
        vecs[1] = '{0, 0, 1, 0, 2'd0, 0, 1, 4'd2, 0};
        vecs[2] = '{0, 0, 1, 1, 2'd1, 0, 1, 4'd4, 1};
        vecs[3] = '{0, 0, 1, 0, 2'd2, 0, 1, 4'd8, 0};
        vecs[4] = '{0, 0, 1, 1, 2'd3, 0, 1, 4'd8, 1};
        vecs[5] = '{1, 0, 1, 0, 2'd1, 0, 1, 4'd4, 0};
        vecs[6] = '{1, 1, 0, 0, 2'd0, 0, 0, 4'd0, 0};
        vecs[7] = '{1, 1, 1, 1, 2'd0, 0, 1, 4'd2, 1};
        vecs[8] = '{0, 0, 0, 1, 2'd3, 0, 0, 4'd0, 0};
        vecs[0].e_nib = 4'd8;

        // Reset state, and no grant in the first cycle after reset.
        do_reset();
        instr_req = 1; data_req = 1; #1;
        chk("rst_quiet_igt", instr_gnt, 0);
        chk("rst_quiet_dgt", data_gnt, 0);
        chk("rst_regs", {mem_addr, mem_write, mem_nibbles}, 0);

        // IDLE arbitration table.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            @(negedge clk);
            instr_req = vecs[i].ireq; instr_abort = vecs[i].iab; data_req = vecs[i].dreq;
            data_write = vecs[i].dwr; data_size = vecs[i].dsz;
            instr_addr = 28'h0ABCDEF; data_addr = 28'h1234567;
            #1;
            chk($sformatf("vec%0d_igt", i), instr_gnt, vecs[i].e_ig);
            chk($sformatf("vec%0d_dgt", i), data_gnt, vecs[i].e_dg);
            @(negedge clk); idle_inputs(); #1;
            ea = vecs[i].e_ig ? 28'h0ABCDEF : (vecs[i].e_dg ? 28'h1234567 : 28'h0);
            chk($sformatf("vec%0d_start", i), mem_start, vecs[i].e_ig | vecs[i].e_dg);
            chk($sformatf("vec%0d_attr", i), {mem_addr, mem_write, mem_nibbles},
                {ea, vecs[i].e_wr, vecs[i].e_nib});
        end

        // Single fetch: nibbles 1..8 on cycles 2..9, IDLE again on cycle 10.
        do_reset();
        start_fetch(28'h0000100, "fetch");
        chk("fetch_attr", {mem_addr, mem_write, mem_nibbles}, {28'h0000100, 1'b0, 4'd8});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); mem_rdata = 4'(k); #1;
            chk($sformatf("fetch_nib%0d", k), {instr_valid, instr_data, instr_done},
                {1'b1, 4'(k), (k == 8)});
        end
        @(negedge clk); mem_ready = 0; data_req = 1; #1;
        chk("fetch_end_valid", instr_valid, 0);
        chk("fetch_idle_after", data_gnt, 1);

        // Byte store with stalls.
        do_reset();
        @(negedge clk); data_req = 1; data_write = 1; data_size = 2'd0; data_addr = 28'h200; #1;
        chk("store_gnt", data_gnt, 1);
        @(negedge clk); data_req = 0; mem_ready = 1; #1;
        chk("store_attr", {mem_start, mem_write, mem_nibbles}, {1'b1, 1'b1, 4'd2});
        pat = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); mem_ready = pat[j]; data_wdata = 4'(j + 5); #1;
            chk($sformatf("store_c%0d", j), {data_valid, data_done, mem_stop, mem_wdata},
                {pat[j], (j == 3), 1'b0, 4'(j + 5)});
        end
        @(negedge clk); mem_ready = 0; #1;
        chk("store_nostop", {mem_stop, data_valid}, 0);

        // Priority with starvation limit.
        do_reset();
        n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            @(negedge clk); instr_req = 1; data_req = 1; data_size = 2'd0; mem_ready = 1; #1;
            if (data_gnt) begin order[n] = 1; n++; end
            else if (instr_gnt) begin order[n] = 0; n++; end
        end
        chk("prio_count", n, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("prio_%0d", k), order[k], exp_order[k]);

        // Fetch abort after three nibbles, with a data request pending.
        do_reset();
        start_fetch(28'h0000500, "abort");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); mem_rdata = 4'(k); #1;
            chk($sformatf("abort_nib%0d", k), instr_valid, 1);
        end
        @(negedge clk); instr_abort = 1; data_req = 1; data_size = 2'd1; #1;
        chk("abort_cycle", {instr_valid, instr_done, data_gnt}, 0);
        @(negedge clk); instr_abort = 0; #1;
        chk("abort_stop", {mem_stop, data_gnt, instr_valid, instr_done}, 4'b1000);
        @(negedge clk); #1;
        chk("abort_then_data", {data_gnt, mem_stop}, 2'b10);
        @(negedge clk); data_req = 0;

        // Abort on the final nibble; abort blocks an IDLE fetch grant.
        do_reset();
        start_fetch(28'h0000600, "lastab");
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); mem_rdata = 4'(k); #1;
            chk($sformatf("lastab_nib%0d", k), {instr_valid, instr_done}, 2'b10);
        end
        @(negedge clk); instr_abort = 1; #1;
        chk("lastab_cycle", {instr_valid, instr_done}, 0);
        @(negedge clk); instr_abort = 0; #1;
        chk("lastab_stop", {mem_stop, instr_done}, 2'b10);
        @(negedge clk); instr_req = 1; instr_abort = 1; #1;
        chk("abort_blocks_gnt", instr_gnt, 0);
        @(negedge clk); instr_abort = 0; #1;
        chk("abort_released_gnt", instr_gnt, 1);
        @(negedge clk); instr_req = 0;

        // Reset in the middle of a 4-nibble load.
        do_reset();
        @(negedge clk); data_req = 1; data_size = 2'd1; data_addr = 28'h300; #1;
        chk("rstmid_gnt", data_gnt, 1);
        @(negedge clk); data_req = 0; mem_ready = 1; #1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk); mem_rdata = 4'(k); #1;
            chk($sformatf("rstmid_nib%0d", k), data_valid, 1);
        end
        @(negedge clk); rst = 1; #1;
        chk("rstmid_during", {data_valid, data_done, mem_start, mem_stop}, 0);
        @(negedge clk); rst = 0; instr_req = 1; instr_addr = 28'h400; #1;
        chk("rstmid_after", {instr_gnt, data_gnt, instr_valid, data_valid, data_done, mem_start,
                             mem_stop, mem_addr, mem_write, mem_nibbles}, 0);
        @(negedge clk); #1;
        chk("rstmid_newgnt", instr_gnt, 1);
        @(negedge clk); instr_req = 0; #1;
        chk("rstmid_start", mem_start, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); mem_rdata = 4'(k); #1;
            chk($sformatf("rstmid_fetch%0d", k), {instr_valid, instr_done}, {1'b1, (k == 8)});
        end

        // Randomized traffic; the reference model checks every cycle.
        do_reset();
        ip = 0; dp = 0; pig = 0; pdg = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (pig) ip = 0;
            if (pdg) dp = 0;
            if (!ip && $urandom_range(3) == 0) begin
                ip = 1; instr_addr = AB'($urandom);
            end
            if (!dp && $urandom_range(2) == 0) begin
                dp = 1; data_addr = AB'($urandom);
                data_write = 1'($urandom); data_size = 2'($urandom);
            end
            instr_req   = ip;
            data_req    = dp;
            instr_abort = ($urandom_range(9) == 0);
            mem_ready   = ($urandom_range(3) != 0);
            mem_rdata   = 4'($urandom);
            data_wdata  = 4'($urandom);
            rst         = ($urandom_range(299) == 0);
            #1;
            pig = instr_gnt; pdg = data_gnt;
        end

        @(negedge clk); idle_inputs(); rst = 0;
        repeat (3) @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
